// File: rtl/multi_monostable.sv
// N-channel clock-synchronous one-shot with 74121-style A_n/B trigger gating.
// Each channel runs a pulse-width counter; retrigger behaviour is chosen per channel.
module multi_monostable #(
  parameter int unsigned         CHANNELS    = 4,
  parameter int unsigned         CNT_W       = 16,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0] RETRIG_MASK = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       a_n,
  input  logic [CHANNELS-1:0]       b,
  input  logic [CHANNELS-1:0]       clr_n,
  input  logic [CHANNELS*CNT_W-1:0] width,
  output logic [CHANNELS-1:0]       q,
  output logic [CHANNELS-1:0]       q_n,
  output logic [CHANNELS-1:0]       ovr
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] a_sync_q, a_sync_d;
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] b_sync_q, b_sync_d;
  logic [CHANNELS-1:0]                  a_p_q, a_p_d, b_p_q, b_p_d;
  logic [CHANNELS-1:0]                  a_s_c, b_s_c, trig_c;
  logic [CHANNELS-1:0]                  st_q, st_d;
  logic [CHANNELS-1:0]                  q_n_q, q_n_d;
  logic [CHANNELS-1:0]                  ovr_q, ovr_d;
  logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [CHANNELS-1:0][CNT_W-1:0]       w_c;

  assign w_c = width;

  // Synchroniser chains plus one extra stage for edge detection.
  always_comb begin
    a_sync_d    = a_sync_q;
    b_sync_d    = b_sync_q;
    a_sync_d[0] = a_n;
    b_sync_d[0] = b;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      a_sync_d[i] = a_sync_q[i-1];
      b_sync_d[i] = b_sync_q[i-1];
    end
    a_s_c  = a_sync_q[SYNC_STAGES-1];
    b_s_c  = b_sync_q[SYNC_STAGES-1];
    a_p_d  = a_s_c;
    b_p_d  = b_s_c;
    trig_c = (a_p_q & ~a_s_c & b_s_c) | (~b_p_q & b_s_c & ~a_s_c);
  end

  // Per-channel next state: clear beats trigger beats countdown.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    ovr_d = ovr_q;
    for (int ch = 0; ch < int'(CHANNELS); ch++) begin
      if (!clr_n[ch]) begin
        st_d[ch]  = ST_IDLE;
        cnt_d[ch] = '0;
        ovr_d[ch] = 1'b0;
      end else if (st_q[ch] == ST_IDLE) begin
        if (trig_c[ch] && (w_c[ch] != '0)) begin
          st_d[ch]  = ST_ACTIVE;
          cnt_d[ch] = w_c[ch] - CNT_W'(1);
        end
      end else if (trig_c[ch] && RETRIG_MASK[ch]) begin
        if (w_c[ch] != '0) begin
          cnt_d[ch] = w_c[ch] - CNT_W'(1);
        end else begin
          st_d[ch]  = ST_IDLE;
          cnt_d[ch] = '0;
        end
      end else begin
        // Non-retriggerable channels record the dropped trigger and keep counting.
        if (trig_c[ch]) begin
          ovr_d[ch] = 1'b1;
        end
        if (cnt_q[ch] == '0) begin
          st_d[ch] = ST_IDLE;
        end else begin
          cnt_d[ch] = cnt_q[ch] - CNT_W'(1);
        end
      end
    end
    q_n_d = ~st_d;
  end

  // Synchroniser presets to idle levels so reset release cannot look like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync_q <= '1;
      b_sync_q <= '0;
      a_p_q    <= '1;
      b_p_q    <= '0;
      st_q     <= '0;
      q_n_q    <= '1;
      ovr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      a_sync_q <= a_sync_d;
      b_sync_q <= b_sync_d;
      a_p_q    <= a_p_d;
      b_p_q    <= b_p_d;
      st_q     <= st_d;
      q_n_q    <= q_n_d;
      ovr_q    <= ovr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign q   = st_q;
  assign q_n = q_n_q;
  assign ovr = ovr_q;

endmodule
